frontpanel_spi_sequencer: RTL and testbench

//  Frame-level front-panel SPI engine between the management register block and SPIHostInterface (sys_clk domain).

---
 rtl/frontpanel_spi_pkg.sv | 20 ++
 rtl/frontpanel_spi_sequencer_if.sv | 31 +++
 rtl/mgmt_commit_fifo.sv | 58 +++++
 rtl/frontpanel_spi_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_frontpanel_spi_sequencer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frontpanel_spi_pkg.sv
// Shared types and helpers for the front-panel SPI frame sequencer.
package frontpanel_spi_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        WAIT_DONE,
        CS_HOLD,
        CS_IDLE
    } seqstate_t;

    // Bits needed for a counter running 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frontpanel_spi_sequencer_if.sv
// Management-side write/receive bus plus the byte handshake towards SPIHostInterface.
interface frontpanel_spi_sequencer_if;
    import frontpanel_spi_pkg::*;

    logic              wr_en;
    logic [BYTE_W-1:0] wr_data;
    logic              wr_commit;
    logic              fifo_full;
    logic              overflow;
    logic              ovf_clear;
    logic              busy;
    logic              rx_valid;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_last;
    logic              shift_en;
    logic [BYTE_W-1:0] tx_data;
    logic              shift_done;
    logic [BYTE_W-1:0] spi_rx_data;
    logic              cs_n;

    modport master (
        output wr_en, wr_data, wr_commit, ovf_clear, shift_done, spi_rx_data,
        input  fifo_full, overflow, busy, rx_valid, rx_data, rx_last, shift_en, tx_data, cs_n
    );

    modport slave (
        input  wr_en, wr_data, wr_commit, ovf_clear, shift_done, spi_rx_data,
        output fifo_full, overflow, busy, rx_valid, rx_data, rx_last, shift_en, tx_data, cs_n
    );

endinterface

// File: rtl/mgmt_commit_fifo.sv
// Byte FIFO whose write side is staged behind commit_ptr: bytes become readable only once
// committed, and an uncommitted frame can be rolled back in one cycle.
module mgmt_commit_fifo
    import frontpanel_spi_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [BYTE_W-1:0]        wr_data,
    input  logic                     commit,
    input  logic                     rollback,
    input  logic                     rd_en,
    output logic [BYTE_W-1:0]        rd_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   frame_len
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_next;
    logic              wr_accept;

    always_comb begin
        full      = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
        wr_accept = wr_en & ~full;
        wr_next   = wr_ptr_q + PW'(wr_accept);
        // Length includes a byte written in the same cycle as the commit.
        frame_len = wr_next - commit_ptr_q;
        commit_ptr_d = commit ? wr_next : commit_ptr_q;
        wr_ptr_d     = rollback ? commit_ptr_q : wr_next;
        rd_ptr_d     = rd_ptr_q + PW'(rd_en);
        rd_data      = mem[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/frontpanel_spi_sequencer.sv
// Frame-level front-panel SPI engine: queues committed frames, frames them with cs_n and
// runs the byte-wide shift_en/shift_done handshake, returning each received byte.
module frontpanel_spi_sequencer #(
    parameter int DEPTH      = 32,
    parameter int MAX_FRAMES = 4,
    parameter int CS_SETUP   = 25,
    parameter int CS_HOLD    = 25,
    parameter int CS_IDLE    = 50
) (
    input  logic                        clk,
    input  logic                        rst,
    frontpanel_spi_sequencer_if.slave   bus
);

    import frontpanel_spi_pkg::seqstate_t;
    import frontpanel_spi_pkg::cnt_w;
    import frontpanel_spi_pkg::BYTE_W;

    localparam int LW   = $clog2(DEPTH) + 1;
    localparam int FA   = $clog2(MAX_FRAMES);
    localparam int FPW  = FA + 1;
    localparam int TMAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE)
                                               : ((CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE);
    localparam int CW   = cnt_w(TMAX);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] IDLE_LAST  = CW'(CS_IDLE - 1);

    logic              fifo_full, commit, rollback, rd_en;
    logic [BYTE_W-1:0] rd_data;
    logic [LW-1:0]     frame_len;
    logic              bad_q, bad_d, ovf_q, ovf_d, ovf_ev;

    logic [LW-1:0]     lmem [MAX_FRAMES];
    logic [FPW-1:0]    lwr_q, lwr_d, lrd_q, lrd_d;
    logic              lempty, lfull, lpush, lpop;

    seqstate_t         state_q;
    logic [LW-1:0]     remaining_q;
    logic [CW-1:0]     cnt_q;
    logic              cs_n_q, shift_en_q, rx_valid_q, rx_last_q;
    logic [BYTE_W-1:0] tx_data_q, rx_data_q;
    logic              done_ok, issue;

    mgmt_commit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (bus.wr_en),
        .wr_data   (bus.wr_data),
        .commit    (commit),
        .rollback  (rollback),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .full      (fifo_full),
        .frame_len (frame_len)
    );

    always_comb begin
        lempty   = (lwr_q == lrd_q);
        lfull    = (lwr_q - lrd_q) == FPW'(MAX_FRAMES);
        commit   = 1'b0;
        rollback = 1'b0;
        lpush    = 1'b0;
        ovf_ev   = bus.wr_en & fifo_full;
        bad_d    = bad_q | ovf_ev;
        if (bus.wr_commit && frame_len != '0) begin
            if (bad_d || lfull) begin
                rollback = 1'b1;
                ovf_ev   = 1'b1;
            end else begin
                commit = 1'b1;
                lpush  = 1'b1;
            end
            bad_d = 1'b0;
        end
        // A new overflow event wins over a simultaneous clear.
        ovf_d = ovf_ev ? 1'b1 : (bus.ovf_clear ? 1'b0 : ovf_q);
        lpop  = (state_q == frontpanel_spi_pkg::IDLE) && !lempty;
        lwr_d = lwr_q + FPW'(lpush);
        lrd_d = lrd_q + FPW'(lpop);

        done_ok = (state_q == frontpanel_spi_pkg::WAIT_DONE) && bus.shift_done;
        issue   = ((state_q == frontpanel_spi_pkg::CS_SETUP) && (cnt_q == SETUP_LAST)) ||
                  (done_ok && remaining_q != LW'(1));
        rd_en   = issue;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bad_q <= 1'b0;
            ovf_q <= 1'b0;
            lwr_q <= '0;
            lrd_q <= '0;
        end else begin
            bad_q <= bad_d;
            ovf_q <= ovf_d;
            lwr_q <= lwr_d;
            lrd_q <= lrd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lpush) lmem[lwr_q[FA-1:0]] <= frame_len;
    end

    // shift_en is raised on entry to SHIFT, so it lands one cycle after the previous shift_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= frontpanel_spi_pkg::IDLE;
            remaining_q <= '0;
            cnt_q       <= '0;
            cs_n_q      <= 1'b1;
            shift_en_q  <= 1'b0;
            tx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_last_q   <= 1'b0;
        end else begin
            shift_en_q <= 1'b0;
            rx_valid_q <= 1'b0;
            if (issue) begin
                shift_en_q <= 1'b1;
                tx_data_q  <= rd_data;
            end
            if (done_ok) begin
                rx_valid_q  <= 1'b1;
                rx_data_q   <= bus.spi_rx_data;
                rx_last_q   <= (remaining_q == LW'(1));
                remaining_q <= remaining_q - LW'(1);
            end
            case (state_q)
                frontpanel_spi_pkg::IDLE: begin
                    if (!lempty) begin
                        remaining_q <= lmem[lrd_q[FA-1:0]];
                        cs_n_q      <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= frontpanel_spi_pkg::CS_SETUP;
                    end
                end
                frontpanel_spi_pkg::CS_SETUP: begin
                    if (cnt_q == SETUP_LAST) state_q <= frontpanel_spi_pkg::SHIFT;
                    else                     cnt_q   <= cnt_q + CW'(1);
                end
                frontpanel_spi_pkg::SHIFT: state_q <= frontpanel_spi_pkg::WAIT_DONE;
                frontpanel_spi_pkg::WAIT_DONE: begin
                    if (done_ok) begin
                        if (remaining_q != LW'(1)) begin
                            state_q <= frontpanel_spi_pkg::SHIFT;
                        end else if (CS_HOLD == 1) begin
                            cs_n_q  <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= frontpanel_spi_pkg::CS_IDLE;
                        end else begin
                            // The shift_done cycle is the first hold cycle.
                            cnt_q   <= CW'(1);
                            state_q <= frontpanel_spi_pkg::CS_HOLD;
                        end
                    end
                end
                frontpanel_spi_pkg::CS_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cs_n_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= frontpanel_spi_pkg::CS_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                frontpanel_spi_pkg::CS_IDLE: begin
                    if (cnt_q == IDLE_LAST) state_q <= frontpanel_spi_pkg::IDLE;
                    else                    cnt_q   <= cnt_q + CW'(1);
                end
                default: state_q <= frontpanel_spi_pkg::IDLE;
            endcase
        end
    end

    assign bus.fifo_full = fifo_full;
    assign bus.overflow  = ovf_q;
    assign bus.busy      = !lempty || (state_q != frontpanel_spi_pkg::IDLE);
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_last   = rx_last_q;
    assign bus.shift_en  = shift_en_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.cs_n      = cs_n_q;

endmodule

// File: tb/tb_frontpanel_spi_sequencer.sv
// Scoreboard bench for frontpanel_spi_sequencer with an echoing (~tx) SPI host model.
module tb_frontpanel_spi_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frontpanel_spi_sequencer_if bus();

    frontpanel_spi_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [7:0] tx_q [$];
    logic [8:0] rx_q [$];

    // SPI model controls
    bit stall      = 1'b0;
    bit spi_flush  = 1'b0;
    int spi_lat    = 0;
    int inject_req = 0;

    // timing monitor state
    bit tmg_en     = 1'b1;
    bit cs_prev    = 1'b1;
    bit first_pend = 1'b0;
    bit have_rise  = 1'b0;
    int fall_cyc   = 0;
    int rise_cyc   = 0;
    int done_cyc   = 0;
    int frames     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        int wait_c = 0;
        bit pend = 1'b0;
        int inject_seen = 0;
        logic [7:0] cap = '0;
        bus.shift_done  = 1'b0;
        bus.spi_rx_data = '0;
        forever begin
            @(posedge clk); #1;
            bus.shift_done = 1'b0;
            if (spi_flush) pend = 1'b0;
            if (inject_req != inject_seen) begin
                bus.shift_done  = 1'b1;
                bus.spi_rx_data = 8'hEE;
                inject_seen     = inject_req;
            end else if (bus.shift_en === 1'b1) begin
                pend   = 1'b1;
                wait_c = spi_lat;
                cap    = bus.tx_data;
            end else if (pend && !stall) begin
                if (wait_c == 0) begin
                    bus.shift_done  = 1'b1;
                    bus.spi_rx_data = ~cap;
                    pend            = 1'b0;
                end else begin
                    wait_c--;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus.cs_n === 1'b0 && cs_prev) begin
            frames++;
            fall_cyc   = cyc;
            first_pend = 1'b1;
            if (tmg_en && have_rise) chk("cs_idle_ge50", 32'((cyc - rise_cyc) >= 50), 1);
        end
        if (bus.cs_n === 1'b1 && !cs_prev) begin
            if (tmg_en) begin
                chk("cs_hold", cyc - done_cyc, 25);
                have_rise = 1'b1;
                rise_cyc  = cyc;
            end else begin
                have_rise = 1'b0;
            end
        end
        if (bus.shift_en === 1'b1) begin
            if (first_pend) chk("cs_setup", cyc - fall_cyc, 25);
            else            chk("byte_gap", cyc - done_cyc, 1);
            first_pend = 1'b0;
            if (tx_q.size() == 0) chk("tx_unexpected", {24'b0, bus.tx_data}, 32'h100);
            else                  chk("tx_data", {24'b0, bus.tx_data}, {24'b0, tx_q.pop_front()});
        end
        if (bus.shift_done === 1'b1) done_cyc = cyc;
        if (bus.rx_valid === 1'b1) begin
            if (rx_q.size() == 0) chk("rx_unexpected", {23'b0, bus.rx_last, bus.rx_data}, 32'h200);
            else                  chk("rx_last_data", {23'b0, bus.rx_last, bus.rx_data}, {23'b0, rx_q.pop_front()});
        end
        cs_prev = (bus.cs_n === 1'b1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_commit();
        bus.wr_commit = 1'b1;
        tick();
        bus.wr_commit = 1'b0;
    endtask

    // Frame whose bytes are all expected on the wire and echoed back inverted.
    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input int n, input bit expect_it);
        wr_byte(b0);
        if (n > 1) wr_byte(b1);
        do_commit();
        if (expect_it) begin
            tx_q.push_back(b0);
            if (n > 1) begin
                tx_q.push_back(b1);
                rx_q.push_back({1'b0, ~b0});
                rx_q.push_back({1'b1, ~b1});
            end else begin
                rx_q.push_back({1'b1, ~b0});
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((bus.busy !== 1'b0 || tx_q.size() != 0 || rx_q.size() != 0) && n < 5000) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < 5000), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int f0;
        bus.wr_en     = 1'b0;
        bus.wr_data   = '0;
        bus.wr_commit = 1'b0;
        bus.ovf_clear = 1'b0;
        rst           = 1'b1;
        repeat (3) tick();

        chk("rst_cs_n",      bus.cs_n,      1);
        chk("rst_shift_en",  bus.shift_en,  0);
        chk("rst_tx_data",   bus.tx_data,   0);
        chk("rst_rx_valid",  bus.rx_valid,  0);
        chk("rst_rx_data",   bus.rx_data,   0);
        chk("rst_rx_last",   bus.rx_last,   0);
        chk("rst_busy",      bus.busy,      0);
        chk("rst_overflow",  bus.overflow,  0);
        chk("rst_fifo_full", bus.fifo_full, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Two-byte frame
        spi_lat = 2;
        send_frame(8'hA5, 8'h3C, 2, 1'b1);
        chk("t1_busy", bus.busy, 1);
        wait_idle("t1_done");
        chk("t1_frames", frames, 1);

        // Back-to-back single-byte frames
        spi_lat = 0;
        send_frame(8'h11, 8'h00, 1, 1'b1);
        send_frame(8'h22, 8'h00, 1, 1'b1);
        chk("t2_busy", bus.busy, 1);
        wait_idle("t2_done");
        chk("t2_frames", frames, 3);
        chk("t2_busy_low", bus.busy, 0);

        // Byte FIFO overrun; ovf_clear together with the dropping write must not win
        for (int i = 0; i < 32; i++) wr_byte(8'(i));
        chk("t3_full", bus.fifo_full, 1);
        chk("t3_ovf_pre", bus.overflow, 0);
        bus.ovf_clear = 1'b1;
        wr_byte(8'hFF);
        bus.ovf_clear = 1'b0;
        chk("t3_ovf_set", bus.overflow, 1);
        do_commit();
        chk("t3_full_after", bus.fifo_full, 0);
        repeat (100) tick();
        chk("t3_no_frame", frames, 3);
        chk("t3_busy", bus.busy, 0);
        chk("t3_ovf_sticky", bus.overflow, 1);
        bus.ovf_clear = 1'b1;
        tick();
        bus.ovf_clear = 1'b0;
        chk("t3_ovf_clear", bus.overflow, 0);

        // Length FIFO overrun while the engine is stalled on frame 0
        stall   = 1'b1;
        spi_lat = 1;
        send_frame(8'h10, 8'h01, 2, 1'b1);
        repeat (40) tick();
        for (int i = 0; i < 5; i++) begin
            send_frame(8'(8'h20 + 2 * i), 8'(8'h21 + 2 * i), 2, i < 4);
            if (i == 3) chk("t4_ovf_before", bus.overflow, 0);
        end
        chk("t4_ovf_drop", bus.overflow, 1);
        stall = 1'b0;
        wait_idle("t4_done");
        chk("t4_frames", frames, 8);
        bus.ovf_clear = 1'b1;
        tick();
        bus.ovf_clear = 1'b0;

        // Reset while waiting for shift_done
        stall = 1'b1;
        send_frame(8'h55, 8'h66, 2, 1'b0);
        tx_q.push_back(8'h55);
        repeat (40) tick();
        chk("t5_in_frame", bus.cs_n, 0);
        tmg_en = 1'b0;
        rst    = 1'b1;
        tick();
        chk("t5_cs_n", bus.cs_n, 1);
        chk("t5_busy", bus.busy, 0);
        chk("t5_rx_valid", bus.rx_valid, 0);
        rst       = 1'b0;
        spi_flush = 1'b1;
        tick();
        spi_flush = 1'b0;
        tx_q.delete();
        inject_req++;
        repeat (5) tick();
        chk("t5_late_busy", bus.busy, 0);
        chk("t5_late_cs_n", bus.cs_n, 1);
        stall  = 1'b0;
        tmg_en = 1'b1;
        f0 = frames;
        send_frame(8'h99, 8'h00, 1, 1'b1);
        wait_idle("t5_new_frame");
        chk("t5_frames", frames, f0 + 1);

        // Empty commit, then write and commit in the same cycle
        do_commit();
        chk("t6_empty_busy", bus.busy, 0);
        repeat (10) tick();
        chk("t6_empty_frames", frames, f0 + 1);
        chk("t6_empty_ovf", bus.overflow, 0);
        bus.wr_en     = 1'b1;
        bus.wr_data   = 8'h77;
        bus.wr_commit = 1'b1;
        tick();
        bus.wr_en     = 1'b0;
        bus.wr_commit = 1'b0;
        tx_q.push_back(8'h77);
        rx_q.push_back({1'b1, 8'h88});
        chk("t6_busy", bus.busy, 1);
        wait_idle("t6_done");
        chk("t6_frames", frames, f0 + 2);
        chk("end_ovf", bus.overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
